// File: rtl/serial_addsub_unit.sv
// ============================================================================
// Module   : serial_addsub_unit
// Purpose  : Bit-serial adder/subtractor. Operands are loaded in parallel on
//            start, processed LSB-first through one full-adder cell with a
//            registered carry, and reassembled into a parallel result with
//            carry-out and signed-overflow flags.
// Options  : SERIAL_ADDSUB_BITSTREAM_EN adds sum_bit / sum_bit_valid outputs
//            that expose each computed sum bit as it is produced.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,       // asynchronous, active-low
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
`ifdef SERIAL_ADDSUB_BITSTREAM_EN
    ,
    output logic             sum_bit,
    output logic             sum_bit_valid
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   psum;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               sum_b;
    logic               carry_nx;
    logic [WIDTH-1:0]   psum_nx;
    logic               last_bit;
    logic               accept;

    // Full-adder cell and control decode for the current bit position
    always_comb begin
        sum_b    = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nx = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        psum_nx  = {sum_b, psum[WIDTH-1:1]};
        last_bit = (cnt == LAST_CNT);
        // A new request is only taken when no operation is in flight
        accept   = start && (state != RUN);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; DONE lasts one cycle unless a new start chains on
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand shift registers, carry, bit counter and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            psum     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B and preset the carry
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            psum  <= psum_nx;
            carry <= carry_nx;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                // carry currently holds the carry into the MSB
                result   <= psum_nx;
                cout     <= carry_nx;
                overflow <= carry ^ carry_nx;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

`ifdef SERIAL_ADDSUB_BITSTREAM_EN
    // Registered view of each sum bit as it leaves the adder cell
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_bit       <= 1'b0;
            sum_bit_valid <= 1'b0;
        end else if (state == RUN) begin
            sum_bit       <= sum_b;
            sum_bit_valid <= 1'b1;
        end else begin
            sum_bit       <= 1'b0;
            sum_bit_valid <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire
